seq_array_multiplier: RTL
=========================

# seq_array_multiplier

Parametrised sequential shift-add multiplier: the multi-cycle successor to the team's 4x4 combinational unsigned array multiplier. Operands of WIDTH bits are captured on a start handshake, one partial-product row is accumulated per clock, and the full 2*WIDTH-bit product is presented with a one-cycle done pulse. It serves datapaths where the area of a full combinational array is unwanted, and optionally supports two's-complement operands.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only when busy=0
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse, product valid
- Y  output  2*WIDTH  product; held until the next completion

## Operation
- One clock domain; the reset is synchronous and active-high. Reset values: busy=0, done=0, Y=0, state IDLE, accumulator=0, counter=0.
- FSM states:
  - IDLE: if start, latch A into the multiplicand register (zero-extended to 2*WIDTH), latch B into the multiplier shift register, clear the accumulator, set counter=0, go to RUN.
  - RUN: if multiplier LSB=1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. When counter reaches WIDTH-1 on this edge, load Y with the final sum, go to DONE.
  - DONE: done=1 for this cycle. If start, behave as IDLE+start (back-to-back accept); else go to IDLE.
- busy=1 exactly in RUN. A start while busy=1 is ignored; operands are not re-sampled.
- Arithmetic: unsigned, exact; Y = A*B, never truncated (max (2^W-1)^2 fits 2*WIDTH). Accumulator is 2*WIDTH bits.
- Y changes only on the edge entering DONE; it is stable at all other times, including during a subsequent RUN.
- Reset asserted mid-RUN or in DONE aborts immediately: all state and outputs return to reset values on that edge, and no done pulse is produced. reset overrides start on the same edge.
- No early termination: latency is independent of operand values, including zero operands.

## Timing
- Edge E0: start=1 sampled (state IDLE or DONE) -> RUN, busy=1 after E0.
- Edges E1..E_WIDTH: one partial product per edge. At E_WIDTH, Y is updated, busy drops to 0, and done rises to 1.
- done high for exactly the one cycle following E_WIDTH; it falls at E_WIDTH+1 unless a new result is completing.
- Start-to-done latency: WIDTH clocks. Throughput with back-to-back starts (start held high in DONE): one product per WIDTH+1 clocks.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- Macro SEQ_MULT_SIGNED_EN.
- Defined: A, B, and Y are two's complement. At capture, magnitudes |A| and |B| are taken (|-2^(W-1)| = 2^(W-1), represented exactly as unsigned WIDTH bits) and sign = A[MSB]^B[MSB] is registered. The unsigned core runs unchanged. On entering DONE, Y = sign ? -acc : acc. Latency is unchanged.
- Undefined: purely unsigned; no sign logic is synthesised.

## Test plan
- WIDTH=4, A=3, B=5, start pulse -> busy high for 4 cycles, done pulses exactly 4 clocks after the start edge, Y=15 (0x0F). Repeat for 2x2->4, 3x4->12, 1x1->1, 0x0->0, and 0x9->0 with the same 4-cycle latency.
- WIDTH=4, A=15, B=15 -> Y=225 (0xE1), no truncation; WIDTH=8, A=255, B=255 -> Y=65025.
- Back-to-back: hold start=1 with A=3, B=3 then A=2, B=7 presented at the DONE cycle -> done pulses 5 clocks apart, Y=9 then Y=14; a start asserted mid-RUN is ignored and Y stays 9 until the second completion.
- Reset asserted at RUN cycle 2 of A=7, B=7 -> next edge busy=0, done=0, Y=0; no done pulse follows. A fresh start then gives Y=49.
- SEQ_MULT_SIGNED_EN, WIDTH=4: -3 x 5 -> Y=0xF1 (-15); -8 x -8 -> Y=0x40 (64); -8 x 7 -> Y=0xC8 (-56); latency stays 4 clocks.
- Random sweep of 500 operand pairs against the reference model A*B (both modes) -> zero mismatches; done is never high for two consecutive cycles without a second start.

Source files
------------

// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: one partial-product row per clock, 2*WIDTH-bit exact product.
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined.
module seq_array_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Y
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    y_q, y_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    result;
  logic             last_row;
  logic             accept;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitude of the most negative value wraps to itself, which is exact as unsigned.
  assign a_mag  = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag  = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign result = sign_q ? (~sum + 1'b1) : sum;
`else
  assign a_mag  = A;
  assign b_mag  = B;
  assign result = sum;
`endif

  assign sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_row = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    accept   = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    sign_d   = sign_q;
`endif

    case (state_q)
      IDLE: begin
        accept = start;
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_row) begin
          y_d     = result;
          state_d = DONE;
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start seen in DONE re-arms immediately, giving one product per WIDTH+1 clocks.
    if (accept) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = RUN;
`ifdef SEQ_MULT_SIGNED_EN
      sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Y    = y_q;

endmodule
